// File: rtl/cache_pkg.sv
// cache_pkg: shared encodings for the bus operation initiator (bus ops, snoop results, MESI, FSM states).
`default_nettype none

package cache_pkg;

  typedef enum logic [1:0] {
    OP_READ       = 2'b00,
    OP_WRITE      = 2'b01,
    OP_INVALIDATE = 2'b10,
    OP_RWIM       = 2'b11
  } bus_op_e;

  typedef enum logic [1:0] {
    SNP_NOHIT = 2'b00,
    SNP_HIT   = 2'b01,
    SNP_HITM  = 2'b10,
    SNP_RSVD  = 2'b11
  } snoop_e;

  typedef enum logic [1:0] {
    MESI_M = 2'b00,
    MESI_E = 2'b01,
    MESI_S = 2'b10,
    MESI_I = 2'b11
  } mesi_e;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ISSUE      = 3'd1,
    ST_SNOOP_WAIT = 3'd2,
    ST_WB_WAIT    = 3'd3,
    ST_DATA_WAIT  = 3'd4,
    ST_DONE       = 3'd5
  } init_state_e;

  // Reserved snoop encoding collapses to noHIT.
  function automatic snoop_e snoop_norm(input logic [1:0] raw);
    snoop_e r;
    r = snoop_e'(raw);
    return (r == SNP_RSVD) ? SNP_NOHIT : r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bus_op_initiator.sv
// bus_op_initiator: issues L2 bus operations, resolves snoops (with timeout and HITM reissue), reports final MESI state.
`default_nettype none

module bus_op_initiator
  import cache_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter int SNOOP_TIMEOUT = 8,
  parameter int MAX_RETRY     = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              bus_valid,
  output logic [1:0]        bus_op,
  output logic [ADDR_W-1:0] bus_addr,
  input  logic              snoop_valid,
  input  logic [1:0]        snoop_result,
  input  logic              mem_done,
  output logic              done,
  output logic [1:0]        fill_state,
  output logic              error
);

  localparam int TW = $clog2(SNOOP_TIMEOUT + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam logic [TW-1:0] TO_LAST   = TW'(SNOOP_TIMEOUT - 1);
  localparam logic [TW-1:0] T_ONE     = TW'(1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [RW-1:0] R_ONE     = RW'(1);

  init_state_e       state, state_nxt;
  bus_op_e           op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [TW-1:0]     tcnt_q;
  logic [RW-1:0]     retry_q;
  logic              snp_hit_q;
  mesi_e             fill_q;
  logic              err_q;

  logic   snp_end;
  snoop_e snp_res;
  logic   snp_hitm;
  logic   retry_left;

  // A sampled result always wins over a coincident timeout.
  assign snp_end    = snoop_valid || (tcnt_q == TO_LAST);
  assign snp_res    = snoop_valid ? snoop_norm(snoop_result) : SNP_NOHIT;
  assign snp_hitm   = (snp_res == SNP_HITM);
  assign retry_left = (retry_q < RETRY_MAX);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:       if (req_valid) state_nxt = ST_ISSUE;
      ST_ISSUE:      state_nxt = (op_q == OP_WRITE) ? ST_DATA_WAIT : ST_SNOOP_WAIT;
      ST_SNOOP_WAIT: begin
        if (snp_end) begin
          if (snp_hitm)                  state_nxt = retry_left ? ST_WB_WAIT : ST_DONE;
          else if (op_q == OP_INVALIDATE) state_nxt = ST_DONE;
          else                           state_nxt = ST_DATA_WAIT;
        end
      end
      ST_WB_WAIT:    if (mem_done) state_nxt = ST_ISSUE;
      ST_DATA_WAIT:  if (mem_done) state_nxt = ST_DONE;
      ST_DONE:       state_nxt = ST_IDLE;
      default:       state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == ST_IDLE);
    bus_valid = (state == ST_ISSUE);
    done      = (state == ST_DONE);
    error     = (state == ST_DONE) && err_q;
  end

  assign bus_op     = op_q;
  assign bus_addr   = addr_q;
  assign fill_state = fill_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q      <= OP_READ;
      addr_q    <= '0;
      tcnt_q    <= '0;
      retry_q   <= '0;
      snp_hit_q <= 1'b0;
      fill_q    <= MESI_I;
      err_q     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            op_q    <= bus_op_e'(req_op);
            addr_q  <= req_addr;
            retry_q <= '0;
            err_q   <= 1'b0;
          end
        end
        ST_ISSUE: tcnt_q <= '0;
        ST_SNOOP_WAIT: begin
          if (!snp_end) begin
            tcnt_q <= tcnt_q + T_ONE;
          end else begin
            snp_hit_q <= (snp_res == SNP_HIT);
            if (snp_hitm) begin
              if (retry_left) begin
                retry_q <= retry_q + R_ONE;
              end else begin
                err_q  <= 1'b1;
                fill_q <= MESI_I;
              end
            end else if (op_q == OP_INVALIDATE) begin
              fill_q <= MESI_M;
            end
          end
        end
        ST_DATA_WAIT: begin
          if (mem_done) begin
            case (op_q)
              OP_WRITE: fill_q <= MESI_I;
              OP_RWIM:  fill_q <= MESI_M;
              default:  fill_q <= snp_hit_q ? MESI_S : MESI_E;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bus_op_initiator.sv
// tb_bus_op_initiator: directed and randomized transactions checked against an outcome model of the initiator.
`default_nettype none

module tb_bus_op_initiator;

  localparam int AW = 32;
  localparam int TO = 8;
  localparam int MR = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_op;
  logic [AW-1:0] req_addr;
  logic          bus_valid;
  logic [1:0]    bus_op;
  logic [AW-1:0] bus_addr;
  logic          snoop_valid;
  logic [1:0]    snoop_result;
  logic          mem_done;
  logic          done;
  logic [1:0]    fill_state;
  logic          error;

  always #5 clk = ~clk;

  bus_op_initiator #(.ADDR_W(AW), .SNOOP_TIMEOUT(TO), .MAX_RETRY(MR)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
    .bus_valid(bus_valid), .bus_op(bus_op), .bus_addr(bus_addr),
    .snoop_valid(snoop_valid), .snoop_result(snoop_result),
    .mem_done(mem_done),
    .done(done), .fill_state(fill_state), .error(error)
  );

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;
  int done_cnt = 0;

  // Per-issue snoop plan: delay (>= TO means no snoop, i.e. timeout) and raw result.
  int       sd[8];
  logic [1:0] sr[8];

  always @(negedge clk) begin
    if (bus_valid) pulse_cnt++;
    if (done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] resolved(input int i);
    if (sd[i] >= TO) return 2'b00;
    return (sr[i] == 2'b11) ? 2'b00 : sr[i];
  endfunction

  // Outcome model: final MESI state, error flag and number of bus issues.
  task automatic model(input logic [1:0] op, output logic [1:0] fill, output logic err,
                       output int pulses);
    err = 1'b0; fill = 2'b11; pulses = 1;
    if (op == 2'b01) return;
    for (int i = 0; i <= MR; i++) begin
      pulses = i + 1;
      if (resolved(i) == 2'b10) begin
        if (i == MR) begin err = 1'b1; fill = 2'b11; return; end
      end else begin
        case (op)
          2'b10:   fill = 2'b00;
          2'b11:   fill = 2'b00;
          default: fill = (resolved(i) == 2'b01) ? 2'b10 : 2'b01;
        endcase
        return;
      end
    end
  endtask

  task automatic run_txn(input logic [1:0] op, input logic [AW-1:0] addr,
                         input int wb_dly, input int data_dly, input bit noise);
    logic [1:0] efill;
    logic       eerr;
    int         epulses;
    int         p0, d0, last;
    logic [1:0] res;
    bit         need_data;
    model(op, efill, eerr, epulses);
    p0 = pulse_cnt;
    d0 = done_cnt;
    res = 2'b00;
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_op = op; req_addr = addr;
    tick();
    req_valid = 1'b0; req_op = 2'($urandom); req_addr = $urandom;
    for (int i = 0; i <= MR; i++) begin
      chk("bus_valid_issue", bus_valid, 1);
      chk("bus_op", bus_op, op);
      chk("bus_addr", bus_addr, addr);
      chk("req_ready_busy", req_ready, 0);
      tick();
      if (op == 2'b01) break;
      last = (sd[i] < TO) ? sd[i] : TO - 1;
      for (int k = 0; k <= last; k++) begin
        chk("no_done_snoop", done, 0);
        if (k == sd[i]) begin
          snoop_valid = 1'b1; snoop_result = sr[i]; mem_done = noise;
        end else begin
          snoop_result = 2'($urandom);
        end
        tick();
        snoop_valid = 1'b0; mem_done = 1'b0;
      end
      res = resolved(i);
      if (res == 2'b10 && i < MR) begin
        for (int w = 0; w < wb_dly; w++) begin
          chk("bus_idle_wb", bus_valid, 0);
          tick();
        end
        mem_done = 1'b1;
        tick();
        mem_done = 1'b0;
      end else begin
        break;
      end
    end
    need_data = (op == 2'b01) || (res != 2'b10 && op != 2'b10);
    if (need_data) begin
      for (int w = 0; w < data_dly; w++) begin
        chk("no_done_data", done, 0);
        snoop_valid = noise; snoop_result = 2'b10;
        tick();
        snoop_valid = 1'b0;
      end
      mem_done = 1'b1;
      tick();
      mem_done = 1'b0;
    end
    chk("done", done, 1);
    chk("fill_state", fill_state, efill);
    chk("error", error, eerr);
    chk("bus_pulses", pulse_cnt - p0, epulses);
    tick();
    chk("done_once", done_cnt - d0, 1);
    chk("error_cleared", error, 0);
    chk("req_ready_back", req_ready, 1);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_addr = '0;
    snoop_valid = 1'b0; snoop_result = 2'b00; mem_done = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_ready", req_ready, 1);
    chk("rst_bus_valid", bus_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_fill", fill_state, 2'b11);
    chk("rst_bus_op", bus_op, 2'b00);
    chk("rst_bus_addr", bus_addr, 0);

    // READ, noHIT one cycle in, data two cycles later -> E
    sd[0] = 1; sr[0] = 2'b00;
    run_txn(2'b00, 32'h0000_1000, 0, 2, 1'b0);
    // RWIM: HITM, writeback, reissue, HIT -> M with two issues
    sd[0] = 0; sr[0] = 2'b10; sd[1] = 0; sr[1] = 2'b01;
    run_txn(2'b11, 32'h0000_5A40, 1, 1, 1'b0);
    // READ with HITM every time -> retry exhaustion
    for (int i = 0; i <= MR; i++) begin sd[i] = i; sr[i] = 2'b10; end
    run_txn(2'b00, 32'hCAFE_0000, 2, 0, 1'b0);
    // INVALIDATE with no snoop -> timeout, M
    sd[0] = 99; sr[0] = 2'b10;
    run_txn(2'b10, 32'h0000_0880, 0, 0, 1'b0);
    // INVALIDATE immediate snoop
    sd[0] = 0; sr[0] = 2'b01;
    run_txn(2'b10, 32'h0000_0900, 0, 0, 1'b1);
    // WRITE, data after 5 cycles -> I
    run_txn(2'b01, 32'h0000_2040, 0, 5, 1'b0);
    // READ immediate HIT, immediate data -> S (4-cycle latency)
    sd[0] = 0; sr[0] = 2'b01;
    run_txn(2'b00, 32'h0000_3000, 0, 0, 1'b0);
    // snoop on the timeout cycle wins; reserved result reads as noHIT
    sd[0] = TO - 1; sr[0] = 2'b01;
    run_txn(2'b00, 32'h0000_3040, 0, 1, 1'b1);
    sd[0] = 2; sr[0] = 2'b11;
    run_txn(2'b00, 32'h0000_3080, 0, 1, 1'b0);

    // Reset during DATA_WAIT drops the request
    begin
      int d0;
      d0 = done_cnt;
      req_valid = 1'b1; req_op = 2'b00; req_addr = 32'h0000_4000;
      tick();
      req_valid = 1'b0;
      tick();
      snoop_valid = 1'b1; snoop_result = 2'b01;
      tick();
      snoop_valid = 1'b0;
      tick();
      reset = 1'b1; mem_done = 1'b1;
      tick();
      reset = 1'b0; mem_done = 1'b0;
      chk("mid_rst_ready", req_ready, 1);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_bus_valid", bus_valid, 0);
      chk("mid_rst_fill", fill_state, 2'b11);
      chk("mid_rst_bus_addr", bus_addr, 0);
      tick(); tick(); tick();
      chk("mid_rst_no_done", done_cnt - d0, 0);
      chk("mid_rst_still_idle", req_ready, 1);
      sd[0] = 0; sr[0] = 2'b00;
      run_txn(2'b00, 32'h0000_4000, 0, 0, 1'b0);
    end

    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i <= MR; i++) begin
        sd[i] = $urandom_range(0, TO + 2);
        sr[i] = 2'($urandom);
      end
      run_txn(2'($urandom), $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
              1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/bus_op_initiator.md
BUS_OP_INITIATOR -- requirements
Module: bus_op_initiator

Interface
REQ-001 Parameter ADDR_W, default 32: address width.
REQ-002 Parameter SNOOP_TIMEOUT, default 8: cycles to wait for a snoop result before treating it as noHIT.
REQ-003 Parameter MAX_RETRY, default 3: maximum HITM-forced reissues per request.
REQ-004 clk  in  1: single clock; all logic is on the rising edge.
REQ-005 reset  in  1: synchronous, active-high reset.
REQ-006 req_valid  in  1: the L2 controller requests a bus operation.
REQ-007 req_ready  out  1: the initiator accepts a request this cycle.
REQ-008 req_op  in  2: 00 READ, 01 WRITE, 10 INVALIDATE, 11 RWIM.
REQ-009 req_addr  in  ADDR_W: line address of the request.
REQ-010 bus_valid  out  1: a bus operation is driven this cycle.
REQ-011 bus_op  out  2: operation driven on the bus, same encoding as req_op.
REQ-012 bus_addr  out  ADDR_W: address driven on the bus.
REQ-013 snoop_valid  in  1: a snoop result is present this cycle.
REQ-014 snoop_result  in  2: 00 noHIT, 01 HIT, 10 HITM; 11 is reserved.
REQ-015 mem_done  in  1: the memory transfer has completed (writeback or fill).
REQ-016 done  out  1: one-cycle completion pulse.
REQ-017 fill_state  out  2: final MESI state for the line (M=00, E=01, S=10, I=11); valid while done is high.
REQ-018 error  out  1: one-cycle pulse on retry exhaustion; it coincides with done.

Function
REQ-019 States: IDLE, ISSUE, SNOOP_WAIT, WB_WAIT, DATA_WAIT, DONE.
REQ-020 IDLE behaviour:
- req_ready is 1 only in IDLE.
- When req_valid is 1, the block latches req_op and req_addr, clears the retry counter and moves to ISSUE.
REQ-021 ISSUE behaviour:
- bus_valid is 1 for exactly one cycle, with bus_op and bus_addr taken from the latched values.
- WRITE goes next to DATA_WAIT (no snoop phase).
- All other operations go next to SNOOP_WAIT with the timeout counter cleared.
REQ-022 SNOOP_WAIT counts cycles and samples snoop_result when snoop_valid is 1.
- If the count reaches SNOOP_TIMEOUT without snoop_valid, the result is treated as noHIT.
- A value of 11 is treated as noHIT.
REQ-023 SNOOP_WAIT outcome noHIT or HIT:
- INVALIDATE goes to DONE with fill_state M.
- READ and RWIM go to DATA_WAIT, with the snoop result recorded.
REQ-024 SNOOP_WAIT outcome HITM:
- If retry count is below MAX_RETRY: increment it and go to WB_WAIT.
- Otherwise: go to DONE with error set and fill_state I.
REQ-025 WB_WAIT holds until mem_done (the other cache's writeback), then returns to ISSUE to reissue the same op and address.
REQ-026 DATA_WAIT holds until mem_done, then goes to DONE with fill_state set as follows:
- READ with noHIT gives E.
- READ with HIT gives S.
- RWIM gives M.
- WRITE gives I.
REQ-027 DONE asserts done for one cycle, then returns to IDLE; req_ready stays 0 during DONE.
REQ-028 mem_done is ignored outside WB_WAIT and DATA_WAIT; snoop_valid is ignored outside SNOOP_WAIT.
REQ-029 Simultaneous events in SNOOP_WAIT:
- snoop_valid in the same cycle the timeout expires: the sampled result wins.
- mem_done in that same cycle: it is ignored.
REQ-030 Latency with no stalls:
- READ with an immediate HIT and an immediate mem_done takes 4 cycles from acceptance to the done pulse.
- INVALIDATE with an immediate snoop takes 3 cycles.
REQ-031 bus_op and bus_addr hold their latched values outside ISSUE; only bus_valid qualifies them.

Reset
REQ-032 Reset takes priority over every transition and returns the FSM to IDLE, including in the middle of an operation.
REQ-033 Values the cycle after reset:
- bus_valid=0, done=0, error=0, req_ready=1.
- fill_state=I (11), bus_op=00, bus_addr=0.
- Retry and timeout counters are 0.
REQ-034 A request in flight when reset is asserted is dropped; no done pulse is produced for it.

Structure
REQ-035 The MESI state encodings, snoop result encodings, bus op encodings and the FSM state enum belong in the shared package cache_pkg.
REQ-036 The design is a single module with no sub-module; the timeout and retry counters are inline.

Verification
REQ-037 READ 0x1000, snoop noHIT at cycle 1, mem_done 2 cycles later -> done with fill_state=E (01), error=0, exactly one bus_valid pulse with bus_op=00.
REQ-038 RWIM, HITM, then mem_done, then reissue, HIT, mem_done -> two bus_valid pulses, same address, fill_state=M (00).
REQ-039 READ with HITM returned 4 times in a row (MAX_RETRY=3) -> 4 bus_valid pulses, then done=1 together with error=1 and fill_state=I.
REQ-040 INVALIDATE with no snoop_valid -> timeout after 8 cycles, done with fill_state=M, no mem_done required.
REQ-041 WRITE 0x2040 with mem_done after 5 cycles -> no snoop wait, done with fill_state=I.
REQ-042 Reset asserted during DATA_WAIT -> next cycle IDLE with req_ready=1 and no done pulse; a new READ is then accepted normally.
